// File: rtl/ram_rd_pkg.sv
// Shared types and elaboration helpers for the RAM read packer.
// Default nibble/pack geometry lives here so the top and bench agree.
package ram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_PACK   = 4;
  localparam int OUT_W      = DEF_DATA_W * DEF_PACK;

  function automatic bit rd_lat_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

  function automatic bit depth_ok(input int d);
    return (d >= 2) && ((d & (d - 1)) == 0);
  endfunction

endpackage

// File: rtl/ram_rd_packer_fifo.sv
// First-word-fall-through word buffer with occupancy count.
// Head reads as zero while empty so the stream bus idles clean.
module packer_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          full;
  logic          do_wr;
  logic          do_rd;

  assign empty   = (count == '0);
  assign full    = (count == (AW + 1)'(DEPTH));
  assign do_wr   = wr_en && (!full || rd_en);
  assign do_rd   = rd_en && !empty;
  assign rd_data = empty ? '0 : mem[rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wp] <= wr_data;
  end

endmodule

// File: rtl/ram_rd_packer.sv
// Walks RAM port B over an address range and packs nibbles into words.
// Word credits are taken at first-nibble issue so returns never stall.
module ram_rd_packer
  import ram_rd_pkg::*;
#(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int PACK       = DEF_PACK,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk_50,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [15:0]              word_cnt,
  output logic                     busy,
  output logic                     done,
  output logic                     ram_enb,
  output logic [ADDR_W-1:0]        ram_addrb,
  input  logic [DATA_W-1:0]        ram_doutb,
  output logic [DATA_W*PACK-1:0]   m_data,
  output logic                     m_valid,
  input  logic                     m_ready
);

  localparam int OW = DATA_W * PACK;
  localparam int NW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int LW = 16 + NW;

  if (!rd_lat_ok(RD_LAT)) begin : g_lat_chk
    $error("RD_LAT must be 1 or 2");
  end
  if (!depth_ok(FIFO_DEPTH)) begin : g_depth_chk
    $error("FIFO_DEPTH must be a power of 2 and >= 2");
  end

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] cur_addr;
  logic [LW-1:0]     rd_left;
  logic [LW-1:0]     cur_left;
  logic [NW-1:0]     nib;
  logic [NW-1:0]     cur_nib;
  logic [NW-1:0]     cap_nib;
  logic [CW-1:0]     reserved;
  logic [CW-1:0]     fcount;
  logic [CW:0]       occ;
  logic [RD_LAT-1:0] vpipe;
  logic [OW-1:0]     pack;
  logic [OW-1:0]     wdata;
  logic              launch;
  logic              active;
  logic              first;
  logic              last;
  logic              credit;
  logic              issue;
  logic              take;
  logic              ret;
  logic              fwr;
  logic              fempty;

  // IDLE issues the first read on the start edge itself
  assign launch   = (state == IDLE) && start && (word_cnt != '0);
  assign active   = launch || (state == RUN);
  assign cur_addr = (state == IDLE) ? base_addr : addr;
  assign cur_left = (state == IDLE) ? LW'(word_cnt) * LW'(PACK) : rd_left;
  assign cur_nib  = (state == IDLE) ? '0 : nib;
  assign first    = (cur_nib == '0);
  assign last     = (cur_nib == NW'(PACK - 1));
  assign occ      = (CW + 1)'(fcount) + (CW + 1)'(reserved);
  assign credit   = occ < (CW + 1)'(FIFO_DEPTH);
  assign issue    = active && (cur_left != '0) && (!first || credit);
  assign take     = issue && first;
  assign ret      = vpipe[RD_LAT-1];
  assign fwr      = ret && (cap_nib == NW'(PACK - 1));
  assign m_valid  = !fempty;

  always_comb begin
    wdata = pack;
    wdata[OW-DATA_W +: DATA_W] = ram_doutb;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (word_cnt == '0)
            state_nxt = DONE;
          else if (issue && cur_left == LW'(1))
            state_nxt = DRAIN;
          else
            state_nxt = RUN;
        end
      end
      RUN: begin
        if (issue && cur_left == LW'(1))
          state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!ram_enb && vpipe == '0 && reserved == '0 && fempty)
          state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ram_enb   <= 1'b0;
      ram_addrb <= '0;
      addr      <= '0;
      rd_left   <= '0;
      nib       <= '0;
      cap_nib   <= '0;
      reserved  <= '0;
      vpipe     <= '0;
      pack      <= '0;
    end else begin
      state   <= state_nxt;
      busy    <= (state_nxt == RUN) || (state_nxt == DRAIN);
      done    <= (state_nxt == DONE);
      ram_enb <= issue;
      if (issue) ram_addrb <= cur_addr;
      if (active) begin
        addr    <= issue ? cur_addr + 1'b1 : cur_addr;
        rd_left <= issue ? cur_left - 1'b1 : cur_left;
        nib     <= !issue ? cur_nib : (last ? '0 : cur_nib + 1'b1);
      end
      if (take && !fwr)
        reserved <= reserved + 1'b1;
      else if (fwr && !take)
        reserved <= reserved - 1'b1;
      vpipe <= RD_LAT'({vpipe, ram_enb});
      if (ret) begin
        pack[int'(cap_nib)*DATA_W +: DATA_W] <= ram_doutb;
        cap_nib <= (cap_nib == NW'(PACK - 1)) ? '0 : cap_nib + 1'b1;
      end
    end
  end

  packer_fifo #(
    .W     (OW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_50),
    .rst     (rst),
    .wr_en   (fwr),
    .wr_data (wdata),
    .rd_en   (m_ready),
    .rd_data (m_data),
    .empty   (fempty),
    .count   (fcount)
  );

endmodule

// File: tb/tb_ram_rd_packer.sv
// Directed bench for ram_rd_packer with RD_LAT=1 and RD_LAT=2 builds.
// RAM model returns the low nibble of the address.
module tb_ram_rd_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic [10:0] base_addr = '0;
  logic [15:0] word_cnt = '0;
  logic        m_ready = 1'b0;

  logic        busy, done, ram_enb, m_valid;
  logic [10:0] ram_addrb;
  logic [3:0]  ram_doutb = '0;
  logic [15:0] m_data;

  logic        busy2, done2, enb2, mvalid2;
  logic [10:0] addrb2;
  logic [3:0]  dout2 = '0;
  logic [3:0]  d2_s1 = '0;
  logic [15:0] mdata2;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (ram_enb) ram_doutb <= ram_addrb[3:0];
  end

  always @(posedge clk) begin
    if (enb2) d2_s1 <= addrb2[3:0];
    dout2 <= d2_s1;
  end

  ram_rd_packer #(.RD_LAT(1)) dut (
    .clk_50    (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .word_cnt  (word_cnt),
    .busy      (busy),
    .done      (done),
    .ram_enb   (ram_enb),
    .ram_addrb (ram_addrb),
    .ram_doutb (ram_doutb),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready)
  );

  ram_rd_packer #(.RD_LAT(2)) dut2 (
    .clk_50    (clk),
    .rst       (rst),
    .start     (start2),
    .base_addr (base_addr),
    .word_cnt  (word_cnt),
    .busy      (busy2),
    .done      (done2),
    .ram_enb   (enb2),
    .ram_addrb (addrb2),
    .ram_doutb (dout2),
    .m_data    (mdata2),
    .m_valid   (mvalid2),
    .m_ready   (m_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, done, ram_enb, ram_addrb, m_valid, m_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0",
               {busy, done, ram_enb, ram_addrb, m_valid, m_data});
    end
    checks++;
    if ({busy2, done2, enb2, addrb2, mvalid2, mdata2} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_lat2 got %h want 0",
               {busy2, done2, enb2, addrb2, mvalid2, mdata2});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int first_v = -1;
    int done_n = 0;
    int done_c = -1;
    int busy_fall = -1;
    logic busy1 = 1'b0;
    logic [15:0] q[$];
    logic [15:0] w0, w1;
    base_addr = 11'd0;
    word_cnt = 16'd2;
    m_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 1) busy1 = busy;
      if (m_valid && first_v < 0) first_v = c;
      if (m_valid && m_ready) q.push_back(m_data);
      if (done) begin done_n++; done_c = c; end
      if (!busy && busy_fall < 0) busy_fall = c;
      tick();
    end
    w0 = (q.size() > 0) ? q[0] : 16'hxxxx;
    w1 = (q.size() > 1) ? q[1] : 16'hxxxx;
    checks++;
    if (busy1 !== 1'b1) begin
      errors++; $display("FAIL basic_busy_rise got %b want 1", busy1);
    end
    checks++;
    if (first_v != 6) begin
      errors++; $display("FAIL basic_first_valid got %0d want 6", first_v);
    end
    checks++;
    if (q.size() != 2) begin
      errors++; $display("FAIL basic_word_count got %0d want 2", q.size());
    end
    checks++;
    if (w0 !== 16'h3210) begin
      errors++; $display("FAIL basic_word0 got %h want 3210", w0);
    end
    checks++;
    if (w1 !== 16'h7654) begin
      errors++; $display("FAIL basic_word1 got %h want 7654", w1);
    end
    checks++;
    if (done_n != 1 || done_c != 12) begin
      errors++;
      $display("FAIL basic_done got n=%0d cyc=%0d want n=1 cyc=12", done_n, done_c);
    end
    checks++;
    if (busy_fall != 12) begin
      errors++; $display("FAIL basic_busy_fall got %0d want 12", busy_fall);
    end
  endtask

  task automatic test_wrap();
    logic [10:0] aq[$];
    logic [15:0] q[$];
    logic [10:0] ea[4];
    logic [10:0] got;
    logic [15:0] w0;
    ea = '{11'd2046, 11'd2047, 11'd0, 11'd1};
    base_addr = 11'd2046;
    word_cnt = 16'd1;
    m_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (ram_enb) aq.push_back(ram_addrb);
      if (m_valid && m_ready) q.push_back(m_data);
      tick();
    end
    checks++;
    if (aq.size() != 4) begin
      errors++; $display("FAIL wrap_issue_count got %0d want 4", aq.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < aq.size()) ? aq[i] : 11'bx;
      checks++;
      if (got !== ea[i]) begin
        errors++; $display("FAIL wrap_addr%0d got %0d want %0d", i, got, ea[i]);
      end
    end
    w0 = (q.size() > 0) ? q[0] : 16'hxxxx;
    checks++;
    if (w0 !== 16'h10FE || q.size() != 1) begin
      errors++;
      $display("FAIL wrap_data got %h (n=%0d) want 10fe (n=1)", w0, q.size());
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_w[8];
    logic [15:0] q[$];
    logic [15:0] held = '0;
    logic [15:0] got;
    logic held_v = 1'b0;
    logic mv40 = 1'b0;
    int enb_n = 0;
    int chg = 0;
    int done_n = 0;
    exp_w = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC,
              16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
    base_addr = 11'd0;
    word_cnt = 16'd8;
    m_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (ram_enb) enb_n++;
      if (m_valid) begin
        if (!held_v) begin held = m_data; held_v = 1'b1; end
        else if (m_data !== held) chg++;
      end
      if (c == 40) mv40 = m_valid;
      tick();
    end
    m_ready = 1'b1;
    for (int c = 0; c < 300 && done_n == 0; c++) begin
      if (m_valid && m_ready) q.push_back(m_data);
      if (done) done_n++;
      tick();
    end
    tick();
    checks++;
    if (enb_n != 16) begin
      errors++; $display("FAIL bp_issue_stop got %0d want 16", enb_n);
    end
    checks++;
    if (chg != 0 || held !== 16'h3210) begin
      errors++;
      $display("FAIL bp_hold got changes=%0d head=%h want 0 / 3210", chg, held);
    end
    checks++;
    if (mv40 !== 1'b1) begin
      errors++; $display("FAIL bp_valid_stall got %b want 1", mv40);
    end
    checks++;
    if (q.size() != 8) begin
      errors++; $display("FAIL bp_word_count got %0d want 8", q.size());
    end
    for (int i = 0; i < 8; i++) begin
      got = (i < q.size()) ? q[i] : 16'hxxxx;
      checks++;
      if (got !== exp_w[i]) begin
        errors++; $display("FAIL bp_word%0d got %h want %h", i, got, exp_w[i]);
      end
    end
    checks++;
    if (done_n != 1) begin
      errors++; $display("FAIL bp_done got %0d want 1", done_n);
    end
  endtask

  task automatic test_zero();
    int enb_n = 0;
    int done_n = 0;
    int done_c = -1;
    int busy_n = 0;
    base_addr = 11'd5;
    word_cnt = 16'd0;
    m_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (ram_enb) enb_n++;
      if (busy) busy_n++;
      if (done) begin done_n++; done_c = c; end
      tick();
    end
    checks++;
    if (enb_n != 0) begin
      errors++; $display("FAIL zero_no_issue got %0d want 0", enb_n);
    end
    checks++;
    if (done_n != 1 || done_c != 1) begin
      errors++;
      $display("FAIL zero_done got n=%0d cyc=%0d want n=1 cyc=1", done_n, done_c);
    end
    checks++;
    if (busy_n != 0) begin
      errors++; $display("FAIL zero_busy got %0d want 0", busy_n);
    end
  endtask

  task automatic test_reset_mid();
    int enb_n = 0;
    int c6 = -1;
    int val_n = 0;
    logic [15:0] q[$];
    logic [15:0] w0;
    base_addr = 11'd0;
    word_cnt = 16'd4;
    m_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 20 && c6 < 0; c++) begin
      if (ram_enb) enb_n++;
      if (enb_n == 6) c6 = c;
      else tick();
    end
    checks++;
    if (c6 != 6) begin
      errors++; $display("FAIL mid_sixth_issue got %0d want 6", c6);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({busy, done, ram_enb, ram_addrb, m_valid, m_data} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs got %h want 0",
               {busy, done, ram_enb, ram_addrb, m_valid, m_data});
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (m_valid || ram_enb) val_n++;
      tick();
    end
    checks++;
    if (val_n != 0) begin
      errors++; $display("FAIL mid_flushed got %0d want 0", val_n);
    end
    base_addr = 11'd4;
    word_cnt = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (m_valid && m_ready) q.push_back(m_data);
      tick();
    end
    w0 = (q.size() > 0) ? q[0] : 16'hxxxx;
    checks++;
    if (w0 !== 16'h7654 || q.size() != 1) begin
      errors++;
      $display("FAIL mid_restart got %h (n=%0d) want 7654 (n=1)", w0, q.size());
    end
  endtask

  task automatic test_lat2();
    int first_v = -1;
    int enb_n = 0;
    int done_n = 0;
    logic [15:0] q[$];
    logic [15:0] w0, w1;
    base_addr = 11'd0;
    word_cnt = 16'd2;
    m_ready = 1'b1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      start2 = (c == 3) || (c == 8);
      if (c == 3 || c == 8) begin
        base_addr = 11'd100;
        word_cnt = 16'd5;
      end
      if (mvalid2 && first_v < 0) first_v = c;
      if (enb2) enb_n++;
      if (mvalid2 && m_ready) q.push_back(mdata2);
      if (done2) done_n++;
      tick();
    end
    start2 = 1'b0;
    w0 = (q.size() > 0) ? q[0] : 16'hxxxx;
    w1 = (q.size() > 1) ? q[1] : 16'hxxxx;
    checks++;
    if (first_v != 7) begin
      errors++; $display("FAIL lat2_first_valid got %0d want 7", first_v);
    end
    checks++;
    if (enb_n != 8) begin
      errors++; $display("FAIL lat2_issue_count got %0d want 8", enb_n);
    end
    checks++;
    if (q.size() != 2 || w0 !== 16'h3210 || w1 !== 16'h7654) begin
      errors++;
      $display("FAIL lat2_data got n=%0d %h %h want n=2 3210 7654", q.size(), w0, w1);
    end
    checks++;
    if (done_n != 1) begin
      errors++; $display("FAIL lat2_done got %0d want 1", done_n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero();
    test_reset_mid();
    test_lat2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
